// File: rtl/xform_stream_driver.sv
// Streaming wrapper around an external 12-bit -> 17-bit combinational transform.
// A valid/ready sink registers each accepted word onto xf_in. The transform
// result is captured one cycle later into a small result FIFO, which feeds a
// valid/ready source. A running count and XOR signature of emitted results are
// kept for checking.
//
// Handshake semantics (both ports): a transfer happens on a rising edge where
// valid and ready are both high. A producer holds valid and data stable until
// that transfer. s_ready is combinational and depends on m_ready, so the sink
// can reuse the slot that a same-cycle pop frees.
module xform_stream_driver #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [11:0]      s_data,
  output logic [11:0]      xf_in,
  input  logic [16:0]      xf_out,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [16:0]      m_data,
  input  logic             clear,
  output logic [CNT_W-1:0] word_cnt,
  output logic [16:0]      sig
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int OW = AW + 1;
  localparam logic [OW-1:0] DEPTH_O = OW'(DEPTH);

  logic [11:0]      r_xf_in;
  logic             r_sv;
  logic [16:0]      r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [OW-1:0]    r_occ;
  logic [CNT_W-1:0] r_word_cnt;
  logic [16:0]      r_sig;

  logic [OW-1:0]    w_load;
  logic             w_ready;
  logic             w_accept;
  logic             w_push;
  logic             w_pop;
  logic             w_m_valid;

  // Credit check: buffered words plus the word in flight must fit in the FIFO,
  // or exactly fill it while the head is leaving this cycle.
  always_comb begin
    w_load    = r_occ + {{AW{1'b0}}, r_sv};
    w_m_valid = (r_occ != '0);
    w_pop     = w_m_valid & m_ready;
    w_ready   = !rst & ((w_load < DEPTH_O) | ((w_load == DEPTH_O) & w_pop));
    w_accept  = s_valid & w_ready;
    w_push    = r_sv;
  end

  // Input stage, capture stage and FIFO bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_xf_in  <= '0;
      r_sv     <= 1'b0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_occ    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (w_accept) begin
        r_xf_in <= s_data;
      end
      r_sv <= w_accept;
      // xf_out reflects the word registered on the previous edge.
      if (w_push) begin
        r_mem[r_wr_ptr] <= xf_out;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_occ <= r_occ + 1'b1;
        2'b01:   r_occ <= r_occ - 1'b1;
        default: r_occ <= r_occ;
      endcase
    end
  end

  // Emitted-word count and XOR signature; clear wins over a same-cycle pop.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      r_word_cnt <= '0;
      r_sig      <= '0;
    end else if (w_pop) begin
      r_word_cnt <= r_word_cnt + 1'b1;
      r_sig      <= r_sig ^ r_mem[r_rd_ptr];
    end
  end

  assign s_ready  = w_ready;
  assign xf_in    = r_xf_in;
  assign m_valid  = w_m_valid;
  assign m_data   = r_mem[r_rd_ptr];
  assign word_cnt = r_word_cnt;
  assign sig      = r_sig;

endmodule

// File: tb/tb_xform_stream_driver.sv
// Bench for xform_stream_driver: a stub transform drives xf_out, a reference
// model tracks every accepted word as (expected result, cycle of accept) and
// a negedge monitor checks ordering, m_valid/s_ready timing and statistics.
module tb_xform_stream_driver;

  localparam int DEPTH = 4;
  localparam int CNT_W = 16;

  logic             clk;
  logic             rst;
  logic             s_valid;
  logic             s_ready;
  logic [11:0]      s_data;
  logic [11:0]      xf_in;
  logic [16:0]      xf_out;
  logic             m_valid;
  logic             m_ready;
  logic [16:0]      m_data;
  logic             clear;
  logic [CNT_W-1:0] word_cnt;
  logic [16:0]      sig;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  logic [16:0]      exp_q[$];
  int               stamp_q[$];
  int               cyc = 0;
  logic [CNT_W-1:0] mdl_cnt = '0;
  logic [16:0]      mdl_sig = '0;
  logic             prev_stall = 1'b0;
  logic [16:0]      prev_data = '0;

  xform_stream_driver #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .xf_in(xf_in), .xf_out(xf_out),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .clear(clear), .word_cnt(word_cnt), .sig(sig)
  );

  // Stand-in for the external transform
  function automatic logic [16:0] xf(input logic [11:0] x);
    logic [16:0] p;
    p = {5'b0, x} * 17'd29;
    return p ^ {x, 5'h15};
  endfunction

  assign xf_out = xf(xf_in);

  // Clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard / monitor
  always @(negedge clk) begin
    logic exp_mv;
    logic exp_sr;
    exp_mv = (exp_q.size() > 0) && (stamp_q[0] + 2 <= cyc);
    exp_sr = !rst && ((exp_q.size() < DEPTH) ||
                      ((exp_q.size() == DEPTH) && exp_mv && m_ready));
    check("m_valid", 32'(m_valid), 32'(exp_mv));
    check("s_ready", 32'(s_ready), 32'(exp_sr));
    check("word_cnt", 32'(word_cnt), 32'(mdl_cnt));
    check("sig", 32'(sig), 32'(mdl_sig));
    if (prev_stall) check("m_data_stable", 32'(m_data), 32'(prev_data));
    prev_stall = !rst && m_valid && !m_ready;
    prev_data  = m_data;
    if (rst) begin
      exp_q.delete();
      stamp_q.delete();
      mdl_cnt = '0;
      mdl_sig = '0;
    end else begin
      if (exp_mv && m_ready) begin
        check("m_data", 32'(m_data), 32'(exp_q[0]));
        if (!clear) begin
          mdl_cnt = mdl_cnt + 1'b1;
          mdl_sig = mdl_sig ^ exp_q[0];
        end
        void'(exp_q.pop_front());
        void'(stamp_q.pop_front());
      end
      if (clear) begin
        mdl_cnt = '0;
        mdl_sig = '0;
      end
      if (s_valid && exp_sr) begin
        exp_q.push_back(xf(s_data));
        stamp_q.push_back(cyc);
      end
    end
    cyc++;
  end

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    s_valid = 1'b0;
    m_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (exp_q.size() == 0) break;
    end
    check("drain_done", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int acc;
    logic [16:0] x;
    rst = 1'b1; s_valid = 1'b0; s_data = '0; m_ready = 1'b0; clear = 1'b0;
    repeat (2) tick();
    @(negedge clk);
    check("rst_m_data", 32'(m_data), 32'd0);
    check("rst_xf_in", 32'(xf_in), 32'd0);
    check("rst_s_ready", 32'(s_ready), 32'd0);
    tick();
    rst = 1'b0;

    // Single word
    s_valid = 1'b1; s_data = 12'h000; m_ready = 1'b1;
    @(negedge clk);
    check("sw_accept", 32'(s_ready), 32'd1);
    tick();
    s_valid = 1'b0;
    @(negedge clk);
    check("sw_xf_in", 32'(xf_in), 32'd0);
    check("sw_mv_lat1", 32'(m_valid), 32'd0);
    tick();
    @(negedge clk);
    check("sw_mv_lat2", 32'(m_valid), 32'd1);
    check("sw_m_data", 32'(m_data), 32'(xf(12'h000)));
    tick();
    @(negedge clk);
    check("sw_cnt", 32'(word_cnt), 32'd1);
    check("sw_sig", 32'(sig), 32'(xf(12'h000)));
    tick();
    s_valid = 1'b1; s_data = 12'habc;
    tick();
    s_valid = 1'b0;
    @(negedge clk);
    check("sw2_xf_in", 32'(xf_in), 32'habc);
    drain();

    // Burst of 8
    clear = 1'b1;
    tick();
    clear = 1'b0;
    x = '0;
    for (int i = 1; i <= 8; i++) begin
      s_valid = 1'b1; s_data = 12'(i);
      x = x ^ xf(12'(i));
      @(negedge clk);
      check("burst_ready", 32'(s_ready), 32'd1);
      tick();
    end
    drain();
    check("burst_cnt", 32'(word_cnt), 32'd8);
    check("burst_sig", 32'(sig), 32'(x));

    // Backpressure
    m_ready = 1'b0; s_valid = 1'b1; acc = 0;
    for (int i = 0; i < 10; i++) begin
      s_data = 12'($urandom_range(0, 4095));
      @(negedge clk);
      if (s_valid && s_ready) acc++;
      tick();
    end
    check("bp_accepts", 32'(acc), 32'(DEPTH));
    m_ready = 1'b1;
    @(negedge clk);
    check("bp_reassert", 32'(s_ready), 32'd1);
    tick();
    drain();

    // Clear coincident with a pop
    m_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      s_valid = 1'b1; s_data = 12'($urandom_range(0, 4095));
      tick();
    end
    s_valid = 1'b0;
    repeat (3) tick();
    m_ready = 1'b1; clear = 1'b1;
    tick();
    m_ready = 1'b0; clear = 1'b0;
    @(negedge clk);
    check("clr_cnt", 32'(word_cnt), 32'd0);
    check("clr_sig", 32'(sig), 32'd0);
    check("clr_fifo", 32'(m_valid), 32'd1);
    tick();
    drain();

    // Random stall
    for (int i = 0; i < 1000; i++) begin
      s_valid = ($urandom_range(0, 3) != 0);
      s_data  = 12'($urandom_range(0, 4095));
      m_ready = ($urandom_range(0, 2) != 0);
      clear   = ($urandom_range(0, 31) == 0);
      tick();
    end
    clear = 1'b0;
    drain();

    // Reset mid-burst: 3 buffered, 1 in flight
    m_ready = 1'b0; s_valid = 1'b1; acc = 0;
    for (int i = 0; i < 10; i++) begin
      s_data = 12'($urandom_range(0, 4095));
      @(negedge clk);
      if (s_valid && s_ready) acc++;
      tick();
      if (acc == 4) break;
    end
    check("mr_accepts", 32'(acc), 32'd4);
    rst = 1'b1; s_valid = 1'b0;
    @(negedge clk);
    check("mr_ready_in_rst", 32'(s_ready), 32'd0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("mr_m_valid", 32'(m_valid), 32'd0);
    check("mr_cnt", 32'(word_cnt), 32'd0);
    check("mr_sig", 32'(sig), 32'd0);
    check("mr_xf_in", 32'(xf_in), 32'd0);
    check("mr_s_ready", 32'(s_ready), 32'd1);
    tick();
    @(negedge clk);
    check("mr_m_valid2", 32'(m_valid), 32'd0);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/xform_stream_driver.md
Name: xform_stream_driver

Overview:
- Streaming front/back end for the team's 12-bit-in / 17-bit-out combinational transform block.
- Accepts 12-bit words on a valid/ready sink and drives each word onto the transform's input bus (xf_in).
- Captures the transform's 17-bit result (xf_out) one cycle later and buffers results in a FIFO for a valid/ready source.
- Keeps a running word count and XOR signature of emitted results for bench and system-level checking.

Parameters:
- DEPTH, 4, result FIFO entries; power of two, minimum 2.
- CNT_W, 16, width of the emitted-word counter.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- s_valid  input  1  input word valid
- s_ready  output  1  block can accept an input word this cycle
- s_data  input  12  input word
- xf_in  output  12  drive to the transform input; registered
- xf_out  input  17  transform result; combinational function of xf_in
- m_valid  output  1  result available
- m_ready  input  1  downstream accepts result
- m_data  output  17  result word (FIFO head)
- clear  input  1  synchronous clear of count and signature only
- word_cnt  output  CNT_W  results emitted since reset/clear; wraps modulo 2^CNT_W
- sig  output  17  XOR of all emitted m_data since reset/clear

Behaviour:
- Reset values, synchronous while rst=1:
  - xf_in=0, stage valid (sv)=0, FIFO empty.
  - m_valid=0, m_data=0, word_cnt=0, sig=0.
  - s_ready=0 during the reset cycle.
- Stage 1, accept:
  - Accept occurs when s_valid & s_ready; xf_in<=s_data and sv<=1 on that edge.
  - With no accept, sv<=0 and xf_in holds its value.
- Stage 2, capture:
  - On each edge with sv=1, xf_out is written to the FIFO tail.
  - xf_out is sampled exactly one cycle after the accept.
- Latency:
  - An accept at edge N puts the result in the FIFO at edge N+1.
  - m_valid rises after edge N+1 if the FIFO was empty, so the minimum accept-to-m_valid latency is 2 cycles.
- FIFO and credit:
  - occ = FIFO occupancy; inflight = sv.
  - s_ready = !rst & (occ + inflight < DEPTH), or (occ + inflight == DEPTH) & m_valid & m_ready.
  - This guarantees no overflow; a capture never finds the FIFO full.
- Output:
  - m_data is the FIFO head; it is held stable while m_valid & !m_ready.
  - m_data is not required to be 0 when empty after the first write.
- Pop: m_valid & m_ready removes the head.
- Push and pop in the same cycle:
  - Occupancy is unchanged.
  - When the FIFO is empty, push and pop cannot coincide; the new word appears the next cycle.
  - No bypass; ordering is preserved strictly FIFO.
- Full:
  - occ=DEPTH -> m_valid=1 and s_ready follows the credit rule above.
  - Pointers wrap modulo DEPTH.
- Statistics: on each pop, word_cnt<=word_cnt+1 and sig<=sig^m_data.
- Clear:
  - clear=1 zeroes word_cnt and sig, overriding any same-cycle pop update.
  - Clear does not affect the FIFO or the pipeline.
- Reset mid-operation:
  - The in-flight word and all FIFO contents are discarded.
  - No m_valid in the cycle after rst deasserts.
- Arithmetic: all widths are unsigned; occupancy is tracked with a log2(DEPTH)+1-bit counter.

Test Plan:
- Single word: s_data=12'h000, m_ready=1.
  - xf_in=0 one cycle after accept.
  - m_valid two cycles after accept; m_data equals the xf_out value presented; word_cnt=1, sig=m_data.
- Burst: 8 words 12'h001..12'h008 back-to-back, m_ready=1.
  - s_ready stays 1.
  - 8 results in order; word_cnt=8; sig = XOR of the 8 results.
- Backpressure: m_ready=0, stream words continuously.
  - Exactly DEPTH=4 words accepted, then s_ready=0.
  - Raising m_ready yields those 4 in order, and s_ready reasserts in the same cycle as the first pop.
- Random stall: random s_valid/m_ready for 1000 cycles.
  - No loss, duplication or reorder versus the reference model.
  - m_data stable while stalled.
- Clear: clear=1 coincident with a pop.
  - word_cnt=0 and sig=0 next cycle.
  - The popped word is not counted; the FIFO is unaffected.
- Reset mid-burst: rst=1 with 3 words buffered and 1 in flight.
  - Next cycle m_valid=0, word_cnt=0, sig=0, xf_in=0.
  - s_ready=1 in the first cycle after rst deasserts.
